// File: rtl/core_pkg.sv
// Shared core constants: instruction width, the bubble instruction, and the default reset PC.
package core_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : core_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and a synchronous flush that
// empties it in one edge. Callers must only assert push/pop when legal.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [DEPTH-1:0] wr_sel;

  // One-hot write enable per entry; flush suppresses any write in the same cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign wr_sel[gi] = push && !flush && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) mem[i] <= wdata;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

endmodule : sync_fifo

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the PC, fetches one word per cycle into a
// prefetch FIFO, hands entries to decode via valid/ready, and flushes on jump.
module if_prefetch
  import core_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] NOP      = NOP_INST
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            rom_addr_o,
  input  logic [INST_W-1:0]          rom_inst_i,
  input  logic                       jump_en_i,
  input  logic [XLEN-1:0]            jump_addr_i,
  input  logic                       id_ready_i,
  output logic                       inst_valid_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [XLEN-1:0]            inst_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int WIDTH = XLEN + INST_W;

  logic [XLEN-1:0]  pc_reg, pc_next;
  logic             push, pop;
  logic             fifo_empty, fifo_full;
  logic [WIDTH-1:0] head;

  // A jump blocks both sides; a full FIFO still accepts when decode drains it this cycle.
  assign pop  = !fifo_empty && id_ready_i && !jump_en_i;
  assign push = !jump_en_i && (!fifo_full || pop);

  always_comb begin
    pc_next = pc_reg;
    if (jump_en_i)  pc_next = {jump_addr_i[XLEN-1:2], 2'b00};
    else if (push)  pc_next = pc_reg + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_reg <= RESET_PC;
    else     pc_reg <= pc_next;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump_en_i),
    .wdata ({pc_reg, rom_inst_i}),
    .rdata (head),
    .count (count_o),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rom_addr_o   = pc_reg;
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? NOP : head[INST_W-1:0];
  assign inst_addr_o  = fifo_empty ? '0  : head[WIDTH-1:INST_W];

endmodule : if_prefetch
